// File: rtl/board_ram_arbiter.sv
// ---------------------------------------------------------------------------
// board_ram_arbiter
//   Single-port access controller for the 160x120x3-bit board RAM. One RAM
//   access per clock is issued, with this priority:
//     display read > clear sweep > player writes (round-robin).
//
// Ports
//   CLOCK_50     in   sole clock, posedge
//   resetn       in   async active-low reset
//   clear_start  in   pulse, begins a board clear (ignored while sweeping)
//   clear_busy   out  high while the clear sweep owns the board
//   wr_req       in   [3:0]  per-player write request, held until acked
//   wr_addr      in   [59:0] player i address {x,y} at [15i+14:15i]
//   wr_data      in   [11:0] player i colour at [3i+2:3i]
//   wr_ack       out  [3:0]  one-hot, combinational grant in the accept cycle
//   rd_req       in   display read request
//   rd_addr      in   [14:0] display read address {x,y}
//   rd_valid     out  read data valid, two cycles after rd_req
//   rd_data      out  [2:0] read colour (0 when not valid)
//   ram_address  out  [14:0] registered RAM address
//   ram_wren     out  registered RAM write enable
//   ram_data     out  [2:0] registered RAM write data
//   ram_q        in   [2:0] RAM read data, one-cycle synchronous latency
// ---------------------------------------------------------------------------

// Coordinate range check for one {x,y} address.
//   i_addr      in   {x[7:0], y[6:0]}
//   o_in_range  out  1 when x <= XM and y <= YM
module board_ram_coord_chk #(
    parameter logic [7:0] XM = 8'd159,
    parameter logic [6:0] YM = 7'd119
) (
    input  logic [14:0] i_addr,
    output logic        o_in_range
);
    assign o_in_range = (i_addr[14:7] <= XM) && (i_addr[6:0] <= YM);
endmodule

module board_ram_arbiter #(
    parameter int unsigned X_MAX        = 159,
    parameter int unsigned Y_MAX        = 119,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        clear_start,
    output logic        clear_busy,
    input  logic [3:0]  wr_req,
    input  logic [59:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic [3:0]  wr_ack,
    input  logic        rd_req,
    input  logic [14:0] rd_addr,
    output logic        rd_valid,
    output logic [2:0]  rd_data,
    output logic [14:0] ram_address,
    output logic        ram_wren,
    output logic [2:0]  ram_data,
    input  logic [2:0]  ram_q
);
    localparam int         NUM_PLAYERS = 4;
    localparam int         RD_STAGES   = 2;
    localparam logic [7:0] XM          = X_MAX[7:0];
    localparam logic [6:0] YM          = Y_MAX[6:0];

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } clr_state_t;

    // ---------------- per-player views ----------------
    logic [NUM_PLAYERS-1:0][14:0] w_paddr;
    logic [NUM_PLAYERS-1:0][2:0]  w_pdata;
    logic [NUM_PLAYERS-1:0]       w_pin;
    logic                         w_rd_in;

    assign w_paddr = wr_addr;
    assign w_pdata = wr_data;

    board_ram_coord_chk #(.XM(XM), .YM(YM)) u_pchk [NUM_PLAYERS-1:0] (
        .i_addr     (w_paddr),
        .o_in_range (w_pin)
    );

    board_ram_coord_chk #(.XM(XM), .YM(YM)) u_rchk (
        .i_addr     (rd_addr),
        .o_in_range (w_rd_in)
    );

    // ---------------- state ----------------
    clr_state_t           r_state;
    clr_state_t           w_state_nxt;
    logic [7:0]           r_cx;
    logic [6:0]           r_cy;
    logic [1:0]           r_ptr;
    logic [14:0]          r_ram_addr;
    logic                 r_ram_wren;
    logic [2:0]           r_ram_data;
    logic [RD_STAGES-1:0] r_rd_vld_pipe;
    logic [RD_STAGES-1:0] r_rd_oor_pipe;

    logic                   w_sweep_go;
    logic                   w_sweep_last;
    logic                   w_wr_en;
    logic [NUM_PLAYERS-1:0] w_req_eff;
    logic                   w_grant_vld;
    logic [1:0]             w_grant_idx;

    // ---------------- clear FSM ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sweep_go   = 1'b0;
        w_sweep_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_start) w_state_nxt = S_SWEEP;
            end
            S_SWEEP: begin
                // The sweep only advances in cycles the display leaves free.
                if (!rd_req) begin
                    w_sweep_go = 1'b1;
                    if (r_cx == XM && r_cy == YM) begin
                        w_sweep_last = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign clear_busy = (r_state == S_SWEEP);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_cx <= 8'd0;
            r_cy <= 7'd0;
        end else if (w_sweep_go) begin
            if (r_cy == YM) begin
                r_cy <= 7'd0;
                r_cx <= w_sweep_last ? 8'd0 : r_cx + 8'd1;
            end else begin
                r_cy <= r_cy + 7'd1;
            end
        end
    end

    // ---------------- player round-robin ----------------
    // resetn is folded in so the combinational ack is silent during reset.
    assign w_wr_en   = resetn && !rd_req && (r_state == S_IDLE);
    assign w_req_eff = wr_req & {NUM_PLAYERS{w_wr_en}};

    // Walk offsets from far to near so the requester closest to the
    // pointer is the one left selected.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = r_ptr;
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            if (w_req_eff[r_ptr + 2'(k)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = r_ptr + 2'(k);
            end
        end
    end

    assign wr_ack = w_grant_vld ? (4'b0001 << w_grant_idx) : 4'b0000;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)          r_ptr <= 2'd0;
        else if (w_grant_vld) r_ptr <= w_grant_idx + 2'd1;
    end

    // ---------------- RAM port ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_ram_addr <= 15'd0;
            r_ram_wren <= 1'b0;
            r_ram_data <= 3'd0;
        end else begin
            r_ram_wren <= 1'b0;
            if (rd_req) begin
                r_ram_addr <= rd_addr;
            end else if (w_sweep_go) begin
                r_ram_addr <= {r_cx, r_cy};
                r_ram_data <= CLEAR_COLOUR;
                r_ram_wren <= 1'b1;
            end else if (w_grant_vld) begin
                // Off-board writes are consumed (acked) but never reach the RAM.
                r_ram_addr <= w_paddr[w_grant_idx];
                r_ram_data <= w_pdata[w_grant_idx];
                r_ram_wren <= w_pin[w_grant_idx];
            end
        end
    end

    assign ram_address = r_ram_addr;
    assign ram_wren    = r_ram_wren;
    assign ram_data    = r_ram_data;

    // ---------------- read return ----------------
    // Stage 0: address registered to the RAM. Stage 1: ram_q is valid.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_rd_vld_pipe <= '0;
            r_rd_oor_pipe <= '0;
        end else begin
            r_rd_vld_pipe <= {r_rd_vld_pipe[RD_STAGES-2:0], rd_req};
            r_rd_oor_pipe <= {r_rd_oor_pipe[RD_STAGES-2:0], !w_rd_in};
        end
    end

    assign rd_valid = r_rd_vld_pipe[RD_STAGES-1];
    assign rd_data  = !rd_valid                     ? 3'b000 :
                      r_rd_oor_pipe[RD_STAGES-1]    ? CLEAR_COLOUR : ram_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
module tb_board_ram_arbiter;
    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        clear_start = 1'b0;
    logic        clear_busy;
    logic [3:0]  wr_req = '0;
    logic [59:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic [3:0]  wr_ack;
    logic        rd_req = 1'b0;
    logic [14:0] rd_addr = '0;
    logic        rd_valid;
    logic [2:0]  rd_data;
    logic [14:0] ram_address;
    logic        ram_wren;
    logic [2:0]  ram_data;
    logic [2:0]  ram_q = '0;

    board_ram_arbiter dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_data    (ram_data),
        .ram_q       (ram_q)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Board RAM model: 1-cycle synchronous read, old data on collision.
    logic [2:0] mem [0:32767];
    always @(posedge CLOCK_50) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    typedef struct { int cyc; logic [3:0] vec; } ack_e_t;
    typedef struct { int cyc; logic [14:0] addr; logic [2:0] data; } wr_e_t;
    typedef struct { int cyc; logic [2:0] data; } rd_e_t;

    ack_e_t q_ack[$];
    wr_e_t  q_wr[$];
    rd_e_t  q_rd[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [14:0] xy(input int x, input int y);
        logic [7:0] xb;
        logic [6:0] yb;
        xb = x[7:0];
        yb = y[6:0];
        return {xb, yb};
    endfunction

    task automatic set_p(input int i, input logic [14:0] a, input logic [2:0] d);
        wr_addr[15*i +: 15] = a;
        wr_data[3*i +: 3]   = d;
    endtask

    task automatic push_ack(input int c, input logic [3:0] v);
        ack_e_t e;
        e.cyc = c; e.vec = v;
        q_ack.push_back(e);
    endtask

    task automatic push_wr(input int c, input logic [14:0] a, input logic [2:0] d);
        wr_e_t e;
        e.cyc = c; e.addr = a; e.data = d;
        q_wr.push_back(e);
    endtask

    task automatic push_rd(input int c, input logic [2:0] d);
        rd_e_t e;
        e.cyc = c; e.data = d;
        q_rd.push_back(e);
    endtask

    task automatic step;
        @(posedge CLOCK_50);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLOCK_50) begin
        ack_e_t ea;
        wr_e_t  ew;
        rd_e_t  er;
        if (wr_ack != 4'b0000) begin
            if (q_ack.size() == 0) chk("ack_unexpected", {28'd0, wr_ack}, 32'd0);
            else begin
                ea = q_ack.pop_front();
                chk("ack_vec", {28'd0, wr_ack}, {28'd0, ea.vec});
                chk("ack_cyc", cyc, ea.cyc);
            end
        end
        if (ram_wren) begin
            if (q_wr.size() == 0) chk("wr_unexpected", {31'd0, ram_wren}, 32'd0);
            else begin
                ew = q_wr.pop_front();
                chk("wr_addr", {17'd0, ram_address}, {17'd0, ew.addr});
                chk("wr_data", {29'd0, ram_data}, {29'd0, ew.data});
                chk("wr_cyc", cyc, ew.cyc);
            end
        end
        if (rd_valid) begin
            if (q_rd.size() == 0) chk("rd_unexpected", {31'd0, rd_valid}, 32'd0);
            else begin
                er = q_rd.pop_front();
                chk("rd_data", {29'd0, rd_data}, {29'd0, er.data});
                chk("rd_cyc", cyc, er.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        int u;
        int g;
        int busy_cnt;
        logic [14:0] ra [6];
        logic [2:0]  rexp [6];

        for (int a = 0; a < 32768; a++) mem[a] = 3'b111;
        resetn = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_busy", {31'd0, clear_busy}, 32'd0);
        chk("rst_ack",  {28'd0, wr_ack}, 32'd0);
        chk("rst_addr", {17'd0, ram_address}, 32'd0);
        chk("rst_wren", {31'd0, ram_wren}, 32'd0);
        chk("rst_data", {29'd0, ram_data}, 32'd0);
        chk("rst_rdv",  {31'd0, rd_valid}, 32'd0);
        chk("rst_rdd",  {29'd0, rd_data}, 32'd0);

        // Test 1: four simultaneous requesters, round-robin from player 1.
        resetn = 1'b1;
        s = cyc;
        set_p(0, xy(1, 2), 3'b001);
        set_p(1, xy(157, 2), 3'b010);
        set_p(2, xy(1, 118), 3'b100);
        set_p(3, xy(157, 118), 3'b110);
        wr_req = 4'hF;
        push_ack(s,     4'b0001); push_wr(s + 1, xy(1, 2),     3'b001);
        push_ack(s + 1, 4'b0010); push_wr(s + 2, xy(157, 2),   3'b010);
        push_ack(s + 2, 4'b0100); push_wr(s + 3, xy(1, 118),   3'b100);
        push_ack(s + 3, 4'b1000); push_wr(s + 4, xy(157, 118), 3'b110);
        for (int i = 0; i < 4; i++) begin
            step;
            wr_req[i] = 1'b0;
        end
        step;

        // Test 2: back-to-back reads starve player 1; it wins when reads stop.
        ra[0] = xy(1, 2);     rexp[0] = 3'b001;
        ra[1] = xy(157, 2);   rexp[1] = 3'b010;
        ra[2] = xy(1, 118);   rexp[2] = 3'b100;
        ra[3] = xy(157, 118); rexp[3] = 3'b110;
        ra[4] = xy(0, 0);     rexp[4] = 3'b111;
        ra[5] = xy(20, 20);   rexp[5] = 3'b111;
        set_p(0, xy(5, 5), 3'b011);
        wr_req = 4'b0001;
        rd_req = 1'b1;
        for (int j = 0; j < 6; j++) begin
            rd_addr = ra[j];
            push_rd(cyc + 2, rexp[j]);
            step;
        end
        rd_req = 1'b0;
        push_ack(cyc, 4'b0001);
        push_wr(cyc + 1, xy(5, 5), 3'b011);
        step;
        wr_req = 4'b0000;
        repeat (3) step;

        // Test 3: clear sweep with no other traffic; a repeat start is ignored.
        s = cyc;
        clear_start = 1'b1;
        for (int k = 0; k < 19200; k++) push_wr(s + 2 + k, xy(k / 120, k % 120), 3'b000);
        step;
        clear_start = 1'b0;
        chk("clr_busy_rise", {31'd0, clear_busy}, 32'd1);
        busy_cnt = 0;
        for (int n = 1; n <= 19210; n++) begin
            if (clear_busy) busy_cnt++;
            clear_start = (n == 5000);
            step;
        end
        clear_start = 1'b0;
        chk("clr_busy_len", busy_cnt, 32'd19200);

        // Seed a colour far ahead of the next sweep's read window.
        set_p(0, xy(150, 50), 3'b101);
        wr_req = 4'b0001;
        push_ack(cyc, 4'b0001);
        push_wr(cyc + 1, xy(150, 50), 3'b101);
        step;
        wr_req = 4'b0000;
        step;

        // Test 4: reads on alternate cycles for the first 19200 sweep cycles,
        // player 3 waiting for the whole sweep.
        s = cyc;
        clear_start = 1'b1;
        for (int k = 0; k < 19200; k++) begin
            g = (k < 9600) ? (s + 2 + 2 * k) : (s + 19201 + (k - 9600));
            push_wr(g + 1, xy(k / 120, k % 120), 3'b000);
        end
        for (int j = 0; j < 9600; j++) push_rd(s + 3 + 2 * j, 3'b101);
        push_ack(s + 28801, 4'b0100);
        push_wr(s + 28802, xy(10, 10), 3'b011);
        step;
        clear_start = 1'b0;
        set_p(2, xy(10, 10), 3'b011);
        wr_req = 4'b0100;
        rd_addr = xy(150, 50);
        busy_cnt = 0;
        for (int n = 1; n <= 28800; n++) begin
            if (clear_busy) busy_cnt++;
            rd_req = (n <= 19199) && (n % 2 == 1);
            step;
        end
        rd_req = 1'b0;
        chk("clr2_busy_len", busy_cnt, 32'd28800);
        chk("clr2_busy_fall", {31'd0, clear_busy}, 32'd0);
        step;
        wr_req = 4'b0000;
        repeat (2) step;

        // Test 5: off-board writes, then two players on the same cell.
        set_p(3, xy(3, 120), 3'b111);
        wr_req = 4'b1000;
        push_ack(cyc, 4'b1000);
        step;
        set_p(1, xy(160, 3), 3'b111);
        wr_req = 4'b0010;
        push_ack(cyc, 4'b0010);
        step;
        // pointer now at player 3: player 1 goes before player 2
        set_p(0, xy(20, 20), 3'b001);
        set_p(1, xy(20, 20), 3'b010);
        wr_req = 4'b0011;
        push_ack(cyc, 4'b0001);     push_wr(cyc + 1, xy(20, 20), 3'b001);
        push_ack(cyc + 1, 4'b0010); push_wr(cyc + 2, xy(20, 20), 3'b010);
        step;
        wr_req = 4'b0010;
        step;
        wr_req = 4'b0000;
        repeat (2) step;
        rd_req = 1'b1;
        rd_addr = xy(200, 5);  push_rd(cyc + 2, 3'b000); step;
        rd_addr = xy(20, 20);  push_rd(cyc + 2, 3'b010); step;
        rd_addr = xy(3, 120);  push_rd(cyc + 2, 3'b000); step;
        rd_req = 1'b0;
        repeat (3) step;

        // Test 6: reset in the middle of a sweep with a read in flight.
        s = cyc;
        clear_start = 1'b1;
        for (int k = 0; k < 7; k++) push_wr(s + 2 + k, xy(0, k), 3'b000);
        step;
        clear_start = 1'b0;
        while (cyc < s + 8) step;
        rd_req = 1'b1;
        rd_addr = xy(1, 2);
        step;
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) set_p(i, xy(30, i), 3'(i + 1));
        wr_req = 4'hF;
        step;
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, clear_busy}, 32'd0);
        chk("mid_rst_ack",  {28'd0, wr_ack}, 32'd0);
        chk("mid_rst_addr", {17'd0, ram_address}, 32'd0);
        chk("mid_rst_wren", {31'd0, ram_wren}, 32'd0);
        chk("mid_rst_data", {29'd0, ram_data}, 32'd0);
        chk("mid_rst_rdv",  {31'd0, rd_valid}, 32'd0);
        chk("mid_rst_rdd",  {29'd0, rd_data}, 32'd0);
        step;
        step;
        resetn = 1'b1;
        u = cyc;
        chk("post_rst_busy", {31'd0, clear_busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            push_ack(u + i, 4'b0001 << i);
            push_wr(u + i + 1, xy(30, i), 3'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            step;
            wr_req[i] = 1'b0;
        end
        repeat (5) step;

        chk("left_ack", q_ack.size(), 32'd0);
        chk("left_wr",  q_wr.size(),  32'd0);
        chk("left_rd",  q_rd.size(),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/board_ram_arbiter.md
# board_ram_arbiter

Single-port access controller for the 160x120x3-bit board RAM. It shares one RAM port among three kinds of traffic: four player write requesters (the trail painters), a display read requester (the VGA scan-out), and a built-in clear sweep that blanks the board before a new game. It sits between the mechanics logic and the RAM and issues at most one RAM access per CLOCK_50 cycle.

## Interface
Parameters:
- X_MAX, 159, largest legal x (address bits [14:7])
- Y_MAX, 119, largest legal y (address bits [6:0])
- CLEAR_COLOUR, 3'b000, value written by the clear sweep and returned for out-of-range reads

Ports:
- CLOCK_50  in  1  sole clock; all logic on posedge
- resetn  in  1  asynchronous, active-low reset
- clear_start  in  1  pulse; starts a board clear
- clear_busy  out  1  high while the clear sweep runs
- wr_req  in  4  bit i = player i+1 write request; held until acked
- wr_addr  in  60  player i address at [15i+14:15i], {x[7:0],y[6:0]}
- wr_data  in  12  player i colour at [3i+2:3i]
- wr_ack  out  4  one-hot, combinational grant in the accept cycle
- rd_req  in  1  display read request, one per cycle allowed
- rd_addr  in  15  display read address {x,y}
- rd_valid  out  1  rd_data valid
- rd_data  out  3  read colour
- ram_address  out  15  registered RAM address
- ram_wren  out  1  registered RAM write enable
- ram_data  out  3  registered RAM write data
- ram_q  in  3  RAM read data, 1-cycle synchronous latency

## Operation
- Per-cycle priority: rd_req > clear sweep > player writes.
- Player arbitration is round-robin. The 2-bit pointer resets to 0 (player 1). The search starts at the pointer. After granting player i, pointer = (i+1) mod 4. The pointer is unchanged when no player is granted.
- While clear_busy = 1, no wr_ack is issued; players stay pending.
- A granted write drives ram_address=wr_addr[i], ram_data=wr_data[i], ram_wren=1 in the next cycle.
- Out-of-range write (x>X_MAX or y>Y_MAX): still acked and the pointer still advances, but ram_wren stays 0.
- A cycle with no grant drives ram_wren=0 and holds ram_address.
- Read: ram_address=rd_addr and ram_wren=0 next cycle. rd_valid is high 2 cycles after rd_req, with rd_data=ram_q.
- Out-of-range read: rd_valid still asserts, with rd_data=CLEAR_COLOUR.
- Clear FSM has two states, IDLE and SWEEP:
  - IDLE -> SWEEP on clear_start.
  - clear_start while in SWEEP is ignored.
  - Sweep counters: x 0..X_MAX outer, y 0..Y_MAX inner. Address {x,y}, data CLEAR_COLOUR, wren=1.
  - Counters advance only in cycles where the sweep wins the port, i.e. no rd_req.
  - SWEEP -> IDLE after the grant of (X_MAX,Y_MAX); exactly 19200 writes.
- Same-address writes from two players: both are performed in round-robin order; the later write wins.

## Timing
- Reset (async assert, sync release): ram_address=0, ram_wren=0, ram_data=0, rd_valid=0, rd_data=0 (combinational from ram_q gated by rd_valid), clear_busy=0, wr_ack=0, pointer=0, sweep counters=0, FSM=IDLE.
- Reset mid-sweep aborts it. Reset also drops any in-flight read valid.
- wr_ack latency 0 (same cycle as accepted wr_req). RAM write lands on the edge after the grant.
- Requesters must drop or replace req/addr/data on the cycle after ack.
- clear_busy rises the cycle after clear_start. It falls the cycle after the final sweep grant; the minimum sweep is 19200 cycles.
- Read latency is fixed at 2 cycles and is unaffected by the other requesters.
- Throughput: one access per cycle.

## Test plan
- Reset, then all four wr_req high with addresses (1,2), (157,2), (1,118), (157,118) → acks in cycles 0,1,2,3 to players 1,2,3,4. Each ram_wren pulse lands one cycle after its ack, with colours 001/010/100/110.
- rd_req every cycle with wr_req[0] held → no wr_ack while rd_req is high. Each read returns rd_valid exactly 2 cycles later. Player 1 is acked the first cycle rd_req drops.
- clear_start, no other traffic → clear_busy high for 19200 cycles. The first write is address 0 and the last is {8'd159,7'd119}; all data is 000. A second clear_start mid-sweep has no effect.
- Clear with rd_req asserted on alternate cycles → sweep still totals 19200 writes and clear_busy lasts 28800 cycles. Pending wr_req[2] is acked in the cycle after clear_busy falls.
- Write to x=160 or y=120 → wr_ack=1, ram_wren stays 0. Read of (200,5) → rd_valid with rd_data=000.
- Assert resetn=0 mid-sweep and mid-read → all outputs are 0 immediately (asynchronously). After release, clear_busy=0 and the next player grant goes to player 1.
